interp_deci_mc: RTL and testbench

Multi-channel rate bridge between an input sample strobe domain and an output sample strobe domain on one clock. Frames of `CH` signed samples are written on `eni`, buffered in a `DEPTH`-frame FIFO, and emitted on `eno`. The bridge has three selectable behaviours for output-rate mismatch: zero-stuffing interpolation, zero-order-hold interpolation, and accumulate-and-dump decimation. It sits in the LPDAQ subsystem between the acquisition front end and the filter chain, and generalises the single-channel zero-stuff/decimate bridge.

---
 rtl/interp_deci_pkg.sv | 32 +++
 rtl/frame_fifo.sv | 67 ++++++
 rtl/interp_deci_mc.sv | 132 +++++++++++++
 tb/tb_interp_deci_mc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_deci_pkg.sv
// ----------------------------------------------------------------------------
// interp_deci_pkg : shared types and helpers for the interp_deci_mc bridge.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package interp_deci_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    HOLD = 2'd1,
    ACC  = 2'd2
  } mode_e;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] acc, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  function automatic int ch_slice(input int c, input int w);
    return c * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_fifo.sv
// ----------------------------------------------------------------------------
// frame_fifo : DEPTH-frame FIFO with pop-before-push and synchronous flush.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_fifo
  import interp_deci_pkg::*;
#(
  parameter int W     = 10,
  parameter int CH    = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W*CH-1:0]              din,
  output logic [W*CH-1:0]              dout,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = W * CH;
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rp];
  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (PW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/interp_deci_mc.sv
// ----------------------------------------------------------------------------
// interp_deci_mc : multi-channel zero-stuff / hold / accumulate-dump bridge.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module interp_deci_mc
  import interp_deci_pkg::*;
#(
  parameter int W     = 10,
  parameter int CH    = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    eni,
  input  logic                    eno,
  input  logic [1:0]              mode,
  input  logic                    clr_flags,
  input  logic [CH*W-1:0]         in,
  output logic [CH*W-1:0]         out,
  output logic                    out_vld,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic                    unf
);

  localparam int AW = W + $clog2(DEPTH) + 1;

  logic [1:0]            mode_q;
  mode_e                 cur;
  logic                  flush;
  logic                  acc_mode;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  got_q;
  logic [CH*W-1:0]       fifo_dout;
  logic [CH*W-1:0]       hold_q;
  logic [CH*W-1:0]       acc_dump;
  logic signed [W-1:0]   in_c    [CH];
  logic signed [AW-1:0]  in_ext  [CH];
  logic signed [AW-1:0]  acc     [CH];
  logic signed [AW-1:0]  acc_add [CH];

  always_comb begin
    case (mode_q)
      2'd1:    cur = HOLD;
      2'd2:    cur = ACC;
      default: cur = ZERO;
    endcase
  end

  assign flush     = (mode != mode_q);
  assign acc_mode  = (cur == ACC);
  assign fifo_push = eni && !flush && !acc_mode;
  assign fifo_pop  = eno && !flush && !acc_mode;
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;
  assign unf_set   = eno && !flush && (acc_mode ? !got_q : fifo_empty);

  // Accumulators clamp at their own range on add; the dump clamps to W bits.
  always_comb begin
    acc_dump = '0;
    for (int c = 0; c < CH; c++) begin
      in_c[c]    = in[ch_slice(c, W) +: W];
      in_ext[c]  = AW'(in_c[c]);
      acc_add[c] = AW'(sat_w(32'(acc[c]) + 32'(in_c[c]), AW));
      acc_dump[ch_slice(c, W) +: W] = W'(sat_w(32'(acc[c]), W));
    end
  end

  frame_fifo #(
    .W     (W),
    .CH    (CH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (in),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      out     <= '0;
      out_vld <= 1'b0;
      hold_q  <= '0;
      got_q   <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      mode_q  <= mode;
      out_vld <= eno && !flush;
      ovf     <= ovf_set | (ovf & ~clr_flags);
      unf     <= unf_set | (unf & ~clr_flags);
      if (flush) begin
        got_q <= 1'b0;
        for (int c = 0; c < CH; c++) acc[c] <= '0;
      end else if (acc_mode) begin
        if (eno) begin
          out   <= acc_dump;
          got_q <= eni;
          for (int c = 0; c < CH; c++) acc[c] <= eni ? in_ext[c] : '0;
        end else if (eni) begin
          got_q <= 1'b1;
          for (int c = 0; c < CH; c++) acc[c] <= acc_add[c];
        end
      end else if (eno) begin
        if (!fifo_empty) begin
          out    <= fifo_dout;
          hold_q <= fifo_dout;
        end else begin
          out <= (cur == HOLD) ? hold_q : '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interp_deci_mc.sv
// ----------------------------------------------------------------------------
// tb_interp_deci_mc : directed bench with a queue-based reference model.
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_interp_deci_mc;

  localparam int W = 10, CH = 4, DEPTH = 4, LW = 3, AW = 13, FW = CH * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          eni = 1'b0;
  logic          eno = 1'b0;
  logic          clr_flags = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [FW-1:0] in_f = '0;
  logic [FW-1:0] out;
  logic          out_vld;
  logic [LW-1:0] level;
  logic          ovf;
  logic          unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interp_deci_mc #(.W(W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .eni       (eni),
    .eno       (eno),
    .mode      (mode),
    .clr_flags (clr_flags),
    .in        (in_f),
    .out       (out),
    .out_vld   (out_vld),
    .level     (level),
    .ovf       (ovf),
    .unf       (unf)
  );

  function automatic int clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [FW-1:0] mkf(input int a, input int b, input int c, input int d);
    logic [FW-1:0] f;
    f[0*W +: W] = W'(a);
    f[1*W +: W] = W'(b);
    f[2*W +: W] = W'(c);
    f[3*W +: W] = W'(d);
    return f;
  endfunction

  function automatic int chv(input logic [FW-1:0] f, input int c);
    return int'($signed(f[c*W +: W]));
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame queue, hold frame, integer accumulators, flags.
  int            mq;
  logic [FW-1:0] q [$];
  logic [FW-1:0] m_hold, m_out;
  int            acc [CH];
  bit            got, m_vld, m_ovf, m_unf, ovs, uns;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq = 0; q.delete(); m_hold = '0; m_out = '0;
      m_vld = 0; m_ovf = 0; m_unf = 0; got = 0;
      for (int c = 0; c < CH; c++) acc[c] = 0;
    end else begin
      ovs = 0; uns = 0; m_vld = 0;
      if (int'(mode) != mq) begin
        q.delete(); got = 0; mq = int'(mode);
        for (int c = 0; c < CH; c++) acc[c] = 0;
      end else if (mq == 2) begin
        if (eno) begin
          m_vld = 1;
          if (!got) uns = 1;
          for (int c = 0; c < CH; c++) begin
            m_out[c*W +: W] = W'(clamp(acc[c], W));
            acc[c] = eni ? chv(in_f, c) : 0;
          end
          got = eni;
        end else if (eni) begin
          for (int c = 0; c < CH; c++) acc[c] = clamp(acc[c] + chv(in_f, c), AW);
          got = 1;
        end
      end else begin
        if (eno) begin
          m_vld = 1;
          if (q.size() > 0) begin
            m_out = q.pop_front();
            m_hold = m_out;
          end else begin
            uns = 1;
            m_out = (mq == 1) ? m_hold : '0;
          end
        end
        if (eni) begin
          if (q.size() < DEPTH) q.push_back(in_f);
          else ovs = 1;
        end
      end
      m_ovf = ovs | (m_ovf & !clr_flags);
      m_unf = uns | (m_unf & !clr_flags);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cmp("model_out", out, m_out);
      cmp("model_vld", out_vld, m_vld);
      cmp("model_level", level, q.size());
      cmp("model_ovf", ovf, m_ovf);
      cmp("model_unf", unf, m_unf);
    end
  end

  task automatic drive(input bit i, input bit o, input logic [FW-1:0] f);
    eni = i; eno = o; in_f = f;
    @(posedge clk);
    #1;
    eni = 1'b0; eno = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #9;
    cmp("rst_out", out, 0);
    cmp("rst_level", level, 0);
    cmp("rst_flags", {ovf, unf, out_vld}, 0);
    #1 rst = 1'b0;

    // ZERO mode
    drive(1, 0, mkf(1, 2, 3, 4));
    drive(1, 0, mkf(5, 6, 7, 8));
    cmp("zero_level2", level, 2);
    drive(0, 1, '0);
    cmp("zero_o1", out, mkf(1, 2, 3, 4));
    cmp("zero_vld", out_vld, 1);
    drive(0, 1, '0);
    cmp("zero_o2", out, mkf(5, 6, 7, 8));
    cmp("zero_unf0", unf, 0);
    drive(0, 1, '0);
    cmp("zero_o3", out, 0);
    cmp("zero_unf1", unf, 1);
    drive(0, 0, '0);
    cmp("zero_vld_off", out_vld, 0);
    clr_flags = 1'b1;
    drive(0, 0, '0);
    cmp("clr_unf", unf, 0);

    // HOLD mode; eno in the flush cycle is ignored
    mode = 2'd1;
    drive(0, 1, '0);
    cmp("hold_flush_vld", out_vld, 0);
    drive(1, 0, mkf(10, -10, 3, 0));
    drive(0, 1, '0);
    cmp("hold_o1", out, mkf(10, -10, 3, 0));
    cmp("hold_unf0", unf, 0);
    drive(0, 1, '0);
    cmp("hold_o2", out, mkf(10, -10, 3, 0));
    cmp("hold_unf1", unf, 1);

    // Overflow and pop-before-push
    mode = 2'd0; clr_flags = 1'b1;
    drive(0, 0, '0);
    for (int k = 1; k <= 5; k++) drive(1, 0, mkf(k, k + 10, -k, 0));
    cmp("ovf_level", level, 4);
    cmp("ovf_set", ovf, 1);
    clr_flags = 1'b1;
    drive(0, 0, '0);
    cmp("ovf_clr", ovf, 0);
    drive(1, 1, mkf(6, 16, -6, 0));
    cmp("full_both_out", out, mkf(1, 11, -1, 0));
    cmp("full_both_ovf", ovf, 0);
    cmp("full_both_level", level, 4);
    drive(0, 1, '0); cmp("drain2", out, mkf(2, 12, -2, 0));
    drive(0, 1, '0); cmp("drain3", out, mkf(3, 13, -3, 0));
    drive(0, 1, '0); cmp("drain4", out, mkf(4, 14, -4, 0));
    drive(0, 1, '0); cmp("drain6", out, mkf(6, 16, -6, 0));
    cmp("drain_level", level, 0);
    drive(1, 1, mkf(9, 9, 9, 9));
    cmp("empty_both_out", out, 0);
    cmp("empty_both_unf", unf, 1);
    cmp("empty_both_level", level, 1);
    drive(0, 1, '0);
    cmp("empty_both_next", out, mkf(9, 9, 9, 9));

    // ACC mode
    mode = 2'd2; clr_flags = 1'b1;
    drive(0, 0, '0);
    for (int k = 0; k < 4; k++) drive(1, 0, mkf(200, -3, 1, 0));
    cmp("acc_level", level, 0);
    drive(0, 1, '0);
    cmp("acc_sat511", out, mkf(511, -12, 4, 0));
    cmp("acc_unf0", unf, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, mkf(-100, 0, 0, -1));
    drive(0, 1, '0);
    cmp("acc_m300", out, mkf(-300, 0, 0, -3));
    drive(1, 0, mkf(5, 0, 0, 0));
    drive(1, 1, mkf(7, 1, 1, 1));
    cmp("acc_excl", out, mkf(5, 0, 0, 0));
    drive(0, 1, '0);
    cmp("acc_incl", out, mkf(7, 1, 1, 1));
    cmp("acc_incl_unf", unf, 0);
    drive(0, 1, '0);
    cmp("acc_empty_out", out, 0);
    cmp("acc_empty_unf", unf, 1);
    for (int k = 0; k < 30; k++) drive(1, 0, mkf(511, -512, 0, 0));
    for (int k = 0; k < 8; k++)  drive(1, 0, mkf(-511, 511, 0, 0));
    drive(0, 1, '0);
    cmp("acc_internal_clamp", out, mkf(7, -8, 0, 0));

    // Mode switch with three frames queued
    mode = 2'd0; clr_flags = 1'b1;
    drive(0, 0, '0);
    for (int k = 1; k <= 3; k++) drive(1, 0, mkf(k, 0, 0, 0));
    cmp("sw_level3", level, 3);
    mode = 2'd1;
    drive(0, 1, '0);
    cmp("sw_level0", level, 0);
    cmp("sw_vld", out_vld, 0);
    cmp("sw_out_kept", out, mkf(7, -8, 0, 0));

    // Asynchronous reset between edges
    for (int k = 1; k <= 5; k++) drive(1, 0, mkf(k, k, k, k));
    drive(0, 1, '0);
    drive(0, 1, '0);
    cmp("pre_rst_level", level, 2);
    cmp("pre_rst_ovf", ovf, 1);
    #1 rst = 1'b1; mode = 2'd0;
    #1;
    cmp("arst_out", out, 0);
    cmp("arst_level", level, 0);
    cmp("arst_flags", {ovf, unf, out_vld}, 0);
    #1 rst = 1'b0;
    clr_flags = 1'b1;
    drive(0, 1, '0);
    cmp("post_rst_vld", out_vld, 1);
    cmp("set_wins_unf", unf, 1);
    drive(0, 0, '0);
    drive(0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
